// File: rtl/cell_plotter.sv
// cell_plotter: turns a latched Life cell (column, row, colour) into the 16
// pixel writes of its 4x4 block for the VGA adapter, and also provides a
// full-screen clear sweep in raster order. All outputs are registered.
module cell_plotter #(
    parameter int GRID_COLS = 40,
    parameter int GRID_ROWS = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ldX,
    input  logic       ldY,
    input  logic       draw,
    input  logic       clear,
    input  logic [6:0] data_in,
    input  logic [2:0] colour_in,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour_out,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam logic [5:0] COL_MAX = 6'(GRID_COLS - 1);
    localparam logic [4:0] ROW_MAX = 5'(GRID_ROWS - 1);
    localparam logic [7:0] X_MAX   = 8'(GRID_COLS * 4 - 1);
    localparam logic [6:0] Y_MAX   = 7'(GRID_ROWS * 4 - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLOT  = 2'd1,
        CLEAR = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state, next_state;

    logic [5:0] col;
    logic [4:0] row;
    logic       draw_q, clear_q;
    logic       draw_start, clear_start;

    logic [7:0] base_x, next_base_x;
    logic [6:0] base_y, next_base_y;
    logic [2:0] col_lat, next_col_lat;
    logic [3:0] pcnt, next_pcnt;
    logic [7:0] cx, next_cx;
    logic [6:0] cy, next_cy;

    logic [7:0] next_x;
    logic [6:0] next_y;
    logic [2:0] next_colour;
    logic       next_plot, next_busy, next_done;

    assign draw_start  = draw & ~draw_q;
    assign clear_start = clear & ~clear_q;

    // Capture the cell coordinates from the switches, clamped onto the grid.
    always_ff @(posedge clock) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else begin
            if (ldX) begin
                col <= (data_in[5:0] > COL_MAX) ? COL_MAX : data_in[5:0];
            end
            if (ldY) begin
                row <= (data_in[4:0] > ROW_MAX) ? ROW_MAX : data_in[4:0];
            end
        end
    end

    // Remember last draw/clear levels so only rising edges start sequences.
    always_ff @(posedge clock) begin
        if (reset) begin
            draw_q  <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            draw_q  <= draw;
            clear_q <= clear;
        end
    end

    // Next-state, counter and pixel-output decode for the plot/clear FSM.
    always_comb begin
        next_state   = state;
        next_base_x  = base_x;
        next_base_y  = base_y;
        next_col_lat = col_lat;
        next_pcnt    = pcnt;
        next_cx      = cx;
        next_cy      = cy;
        next_x       = x_out;
        next_y       = y_out;
        next_colour  = colour_out;
        next_plot    = 1'b0;
        next_done    = 1'b0;

        case (state)
            IDLE: begin
                if (clear_start) begin
                    next_state = CLEAR;
                    next_cx    = '0;
                    next_cy    = '0;
                end else if (draw_start) begin
                    next_state   = PLOT;
                    next_pcnt    = '0;
                    next_base_x  = {2'b00, col} << 2;
                    next_base_y  = {2'b00, row} << 2;
                    next_col_lat = colour_in;
                end
            end
            PLOT: begin
                next_plot   = 1'b1;
                next_x      = base_x + {6'd0, pcnt[1:0]};
                next_y      = base_y + {5'd0, pcnt[3:2]};
                next_colour = col_lat;
                next_pcnt   = pcnt + 4'd1;
                if (pcnt == 4'd15) begin
                    next_state = DONE;
                end
            end
            CLEAR: begin
                next_plot   = 1'b1;
                next_x      = cx;
                next_y      = cy;
                next_colour = 3'd0;
                if (cx == X_MAX) begin
                    next_cx = '0;
                    if (cy == Y_MAX) begin
                        next_cy    = '0;
                        next_state = DONE;
                    end else begin
                        next_cy = cy + 7'd1;
                    end
                end else begin
                    next_cx = cx + 8'd1;
                end
            end
            DONE: begin
                next_done  = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        next_busy = (next_state == PLOT) || (next_state == CLEAR);
    end

    // State, counters and registered VGA outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            base_x     <= '0;
            base_y     <= '0;
            col_lat    <= '0;
            pcnt       <= '0;
            cx         <= '0;
            cy         <= '0;
            x_out      <= '0;
            y_out      <= '0;
            colour_out <= '0;
            plot       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= next_state;
            base_x     <= next_base_x;
            base_y     <= next_base_y;
            col_lat    <= next_col_lat;
            pcnt       <= next_pcnt;
            cx         <= next_cx;
            cy         <= next_cy;
            x_out      <= next_x;
            y_out      <= next_y;
            colour_out <= next_colour;
            plot       <= next_plot;
            busy       <= next_busy;
            done       <= next_done;
        end
    end

endmodule
